prog_load_ctrl: RTL and testbench
=================================

Name: prog_load_ctrl

Overview:
Sequencer for the UART program-loading path. Accepts a byte stream from the UART receiver and assembles it into 32-bit little-endian words. Each word is written into instruction memory, for the first 2^ISCALE words only, and into DRAM through a request/acknowledge port buffered by a small FIFO. Signals `done` once every image word has been acknowledged by DRAM; the CPU stays held off until then.

Parameters:
- ISCALE, 14, log2 of instruction-memory size in words.
- IMAGESCALE, 17, log2 of image size in words (total words loaded).
- FIFO_LOG, 2, log2 of DRAM write FIFO depth (depth 4).

Ports:
- CLK  in  1  clock.
- RST_X  in  1  reset; synchronous, active-low.
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte.
- rx_data  in  8  received byte.
- imem_we  out  1  instruction-memory write strobe (one cycle).
- imem_addr  out  ISCALE  instruction-memory word address.
- imem_wdata  out  32  instruction-memory write data.
- dram_req  out  1  DRAM write request.
- dram_addr  out  IMAGESCALE  DRAM word address.
- dram_wdata  out  32  DRAM write data.
- dram_ack  in  1  DRAM accepted the current request.
- waddr  out  IMAGESCALE+1  count of words acknowledged by DRAM.
- overflow  out  1  sticky: a word was dropped because the FIFO was full.
- done  out  1  load complete.

Behaviour:
- Reset (RST_X=0 at a posedge):
  - All outputs go to 0.
  - Byte counter, word counter, FIFO pointers and FSM are cleared; any partial word is discarded.
  - Reset mid-load aborts the load. The next byte after reset becomes byte 0 of word 0.
- Word assembly:
  - 2-bit byte counter. The k-th accepted byte of a word goes to bits [8k+7:8k], so the first byte lands in the LSB.
  - rx_valid is accepted only in LOAD state; it is ignored in DRAIN and DONE.
- Word completion: the 4th byte is accepted at edge N, with word index w (rcnt).
  - imem: if w < 2^ISCALE, then during cycle N+1 imem_we=1, imem_addr=w[ISCALE-1:0], imem_wdata=word. imem is always ready. For w >= 2^ISCALE, imem_we stays 0.
  - FIFO: {w, word} is pushed at edge N+1.
  - rcnt increments in every case, including when the word is dropped.
- DRAM handshake:
  - dram_req=1 whenever the FIFO is non-empty; dram_addr and dram_wdata show the FIFO head.
  - If dram_req=1 and dram_ack=1 at a posedge, the head is popped and waddr increments.
  - dram_ack is ignored while dram_req=0.
  - Request data stays stable until acknowledged.
  - Back-to-back: when the FIFO is empty, dram_req rises the cycle after the push.
- FIFO boundaries:
  - Push while full with no pop in the same cycle: the word is dropped and overflow=1 (sticky until reset).
  - Push and pop in the same cycle while full: both succeed, no overflow.
  - Pointers wrap modulo depth; full/empty is resolved with an extra pointer bit.
- FSM:
  - LOAD → DRAIN: at the edge where the word with w = 2^IMAGESCALE-1 is pushed (or dropped).
  - DRAIN → DONE: at the first edge where the FIFO is empty and no push is pending.
  - DONE is terminal until reset; done=1 in DONE.
  - Dropped words are never retried. done still rises, with waddr < 2^IMAGESCALE.

Optional Feature:
- Macro PROG_LOAD_CHECKSUM_EN.
- When defined:
  - Adds output `checksum` [31:0], reset 0.
  - Each word, including dropped ones, is added modulo 2^32 at its completion edge.
  - The value is final when done=1.
- When undefined: the port and adder are absent, and behaviour is otherwise identical.

Test Plan:
All tests use ISCALE=2, IMAGESCALE=3, FIFO_LOG=2 unless noted.
1. Bytes 78,56,34,12 (hex), dram_ack=1 → one cycle later imem_we=1, imem_addr=0, imem_wdata=0x12345678. dram_req=1 with addr 0, data 0x12345678. waddr=1 after ack.
2. 8 words (32 bytes), dram_ack=1 → imem_we only for addresses 0..3. DRAM writes addresses 0..7 in order. done=1 one cycle after the 8th ack, waddr=8, overflow=0.
3. dram_ack=0 while words 0..4 arrive → overflow=1 at word 4's push edge. Releasing ack gives DRAM addresses 0,1,2,3 only; later words are written at 5,6,7; done=1, waddr=7.
4. Send 2 bytes, pulse RST_X low for 1 cycle, then bytes 01,00,00,00 → outputs 0 during reset. The first word written is 0x00000001 at address 0.
5. Extra rx_valid bytes after done=1 → no imem_we, no dram_req, waddr unchanged.
6. With PROG_LOAD_CHECKSUM_EN, words 1..8 → checksum=36 (0x24) when done=1.

Source files
------------

// File: rtl/prog_load_ctrl.sv
// UART program-load sequencer: assembles little-endian words, writes imem and DRAM (via FIFO).
// Optional running word checksum output when PROG_LOAD_CHECKSUM_EN is defined.
module prog_load_ctrl #(
  parameter int ISCALE     = 14,
  parameter int IMAGESCALE = 17,
  parameter int FIFO_LOG   = 2
) (
  input  logic                  CLK,
  input  logic                  RST_X,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  imem_we,
  output logic [ISCALE-1:0]     imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  dram_req,
  output logic [IMAGESCALE-1:0] dram_addr,
  output logic [31:0]           dram_wdata,
  input  logic                  dram_ack,
  output logic [IMAGESCALE:0]   waddr,
  output logic                  overflow,
`ifdef PROG_LOAD_CHECKSUM_EN
  output logic [31:0]           checksum,
`endif
  output logic                  done
);

  localparam int DEPTH = 1 << FIFO_LOG;
  localparam logic [IMAGESCALE-1:0] LAST_WORD = {IMAGESCALE{1'b1}};

  typedef enum logic [1:0] {LOAD, DRAIN, FINISHED} state_t;

  state_t                  state, state_next;
  logic [1:0]              byte_cnt;
  logic [23:0]             partial;
  logic [IMAGESCALE-1:0]   rcnt;
  logic                    pend_valid;
  logic [IMAGESCALE-1:0]   pend_idx;
  logic [31:0]             pend_word;
  logic [IMAGESCALE+31:0]  fifo_mem [DEPTH];
  logic [FIFO_LOG:0]       wptr, rptr;
  logic [IMAGESCALE+31:0]  head;
  logic                    accept, word_done, fifo_empty, fifo_full, pop, push_ok;
  logic [31:0]             full_word;

  assign accept     = rx_valid && (state == LOAD);
  assign word_done  = accept && (byte_cnt == 2'd3);
  assign full_word  = {rx_data, partial};
  assign fifo_empty = (wptr == rptr);
  assign fifo_full  = (wptr[FIFO_LOG] != rptr[FIFO_LOG]) &&
                      (wptr[FIFO_LOG-1:0] == rptr[FIFO_LOG-1:0]);
  assign pop        = !fifo_empty && dram_ack;
  assign push_ok    = pend_valid && (!fifo_full || pop);
  assign head       = fifo_mem[rptr[FIFO_LOG-1:0]];

  // Request data is forced to zero when idle so nothing stale leaks out after reset.
  assign dram_req   = !fifo_empty;
  assign dram_addr  = fifo_empty ? '0 : head[IMAGESCALE+31:32];
  assign dram_wdata = fifo_empty ? '0 : head[31:0];

  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      LOAD:     if (pend_valid && (pend_idx == LAST_WORD)) state_next = DRAIN;
      DRAIN:    if (fifo_empty && !pend_valid) state_next = FINISHED;
      FINISHED: done = 1'b1;
      default:  state_next = LOAD;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // A completed word is latched for one cycle: imem sees it now, the FIFO takes it next edge.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      byte_cnt   <= 2'd0;
      partial    <= '0;
      rcnt       <= '0;
      pend_valid <= 1'b0;
      pend_idx   <= '0;
      pend_word  <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we    <= 1'b0;
      pend_valid <= word_done;
      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    partial[7:0]   <= rx_data;
          2'd1:    partial[15:8]  <= rx_data;
          2'd2:    partial[23:16] <= rx_data;
          default: begin
            pend_idx   <= rcnt;
            pend_word  <= full_word;
            rcnt       <= rcnt + IMAGESCALE'(1);
            imem_we    <= ((rcnt >> ISCALE) == '0);
            imem_addr  <= ISCALE'(rcnt);
            imem_wdata <= full_word;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      wptr     <= '0;
      rptr     <= '0;
      waddr    <= '0;
      overflow <= 1'b0;
    end else begin
      if (pop) begin
        rptr  <= rptr + (FIFO_LOG+1)'(1);
        waddr <= waddr + (IMAGESCALE+1)'(1);
      end
      if (push_ok) begin
        wptr <= wptr + (FIFO_LOG+1)'(1);
      end else if (pend_valid) begin
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST_X && push_ok) begin
      fifo_mem[wptr[FIFO_LOG-1:0]] <= {pend_idx, pend_word};
    end
  end

`ifdef PROG_LOAD_CHECKSUM_EN
  // Dropped words still count, so the sum reflects the image as received.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      checksum <= '0;
    end else if (word_done) begin
      checksum <= checksum + full_word;
    end
  end
`endif

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Self-checking bench for prog_load_ctrl with a queue-based reference model.
// Checksum checks are compiled in when PROG_LOAD_CHECKSUM_EN is defined.
module tb_prog_load_ctrl;
  localparam int ISCALE = 2, IMAGESCALE = 3, FIFO_LOG = 2;
  localparam int DEPTH = 4, NWORDS = 8, IMEM_WORDS = 4;

  logic CLK = 1'b0, RST_X = 1'b0, rx_valid = 1'b0, dram_ack = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic imem_we, dram_req, overflow, done;
  logic [ISCALE-1:0] imem_addr;
  logic [31:0] imem_wdata, dram_wdata;
  logic [IMAGESCALE-1:0] dram_addr;
  logic [IMAGESCALE:0] waddr;
`ifdef PROG_LOAD_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int checks = 0, fails = 0;

  // Reference model state: mode 0 = loading, 1 = draining, 2 = done.
  int m_mode, m_bc, m_rcnt, m_pidx, m_waddr, m_iaddr;
  bit m_pend, m_ovf, m_iwe, m_inreset;
  logic [31:0] m_partial, m_pword, m_idata, m_sum;
  logic [34:0] m_q[$];

  prog_load_ctrl #(.ISCALE(ISCALE), .IMAGESCALE(IMAGESCALE), .FIFO_LOG(FIFO_LOG)) dut (
    .CLK(CLK), .RST_X(RST_X), .rx_valid(rx_valid), .rx_data(rx_data),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .dram_req(dram_req), .dram_addr(dram_addr), .dram_wdata(dram_wdata),
    .dram_ack(dram_ack), .waddr(waddr), .overflow(overflow),
`ifdef PROG_LOAD_CHECKSUM_EN
    .checksum(checksum),
`endif
    .done(done)
  );

  always #5 CLK = ~CLK;

  task automatic checkValue(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic modelEdge(input bit rst_n, input bit valid, input logic [7:0] data, input bit ack);
    bit pop, full, qempty, nxt_pend;
    int prev_mode, nxt_pidx, widx;
    logic [31:0] nxt_word;
    if (!rst_n) begin
      m_mode = 0; m_bc = 0; m_rcnt = 0; m_pidx = 0; m_waddr = 0; m_iaddr = 0;
      m_pend = 0; m_ovf = 0; m_iwe = 0; m_inreset = 1;
      m_partial = '0; m_pword = '0; m_idata = '0; m_sum = '0;
      m_q.delete();
    end else begin
      m_inreset = 0;
      prev_mode = m_mode;
      qempty = (m_q.size() == 0);
      full = (m_q.size() == DEPTH);
      pop = !qempty && ack;
      m_iwe = 0;
      nxt_pend = 0; nxt_pidx = 0; nxt_word = '0;
      if (pop) begin
        void'(m_q.pop_front());
        m_waddr++;
      end
      if (m_pend) begin
        if (full && !pop) m_ovf = 1;
        else m_q.push_back({3'(m_pidx), m_pword});
      end
      if (prev_mode == 0 && m_pend && m_pidx == NWORDS - 1) m_mode = 1;
      if (prev_mode == 1 && qempty && !m_pend) m_mode = 2;
      if (prev_mode == 0 && valid) begin
        m_partial[8*m_bc +: 8] = data;
        if (m_bc == 3) begin
          widx = m_rcnt % NWORDS;
          nxt_pend = 1; nxt_pidx = widx; nxt_word = m_partial;
          if (widx < IMEM_WORDS) begin
            m_iwe = 1; m_iaddr = widx; m_idata = m_partial;
          end
          m_sum = m_sum + m_partial;
          m_rcnt++;
          m_bc = 0;
        end else begin
          m_bc++;
        end
      end
      m_pend = nxt_pend; m_pidx = nxt_pidx; m_pword = nxt_word;
    end
  endtask

  task automatic checkOutput();
    checkValue("done", done, m_mode == 2);
    checkValue("overflow", overflow, m_ovf);
    checkValue("waddr", waddr, m_waddr);
    checkValue("imem_we", imem_we, m_iwe);
    if (m_iwe || m_inreset) begin
      checkValue("imem_addr", imem_addr, m_iaddr);
      checkValue("imem_wdata", imem_wdata, m_idata);
    end
    checkValue("dram_req", dram_req, m_q.size() > 0);
    if (m_q.size() > 0) begin
      checkValue("dram_addr", dram_addr, m_q[0][34:32]);
      checkValue("dram_wdata", dram_wdata, m_q[0][31:0]);
    end else if (m_inreset) begin
      checkValue("dram_addr_rst", dram_addr, 0);
      checkValue("dram_wdata_rst", dram_wdata, 0);
    end
`ifdef PROG_LOAD_CHECKSUM_EN
    checkValue("checksum", checksum, m_sum);
`endif
  endtask

  task automatic applyStimulus(input bit rst_n, input bit valid, input logic [7:0] data, input bit ack);
    RST_X = rst_n; rx_valid = valid; rx_data = data; dram_ack = ack;
    @(posedge CLK);
    modelEdge(rst_n, valid, data, ack);
    #1;
    checkOutput();
  endtask

  function automatic bit ackFor(input int ack_mode);
    if (ack_mode == 2) return 1'($urandom_range(0, 1));
    return ack_mode[0];
  endfunction

  task automatic sendByte(input logic [7:0] b, input int ack_mode, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    for (int i = 0; i < gap; i++) applyStimulus(1, 0, 8'h00, ackFor(ack_mode));
    applyStimulus(1, 1, b, ackFor(ack_mode));
  endtask

  task automatic sendWord(input logic [31:0] w, input int ack_mode, input int max_gap);
    for (int k = 0; k < 4; k++) sendByte(w[8*k +: 8], ack_mode, max_gap);
  endtask

  task automatic resetDut(input int cycles);
    for (int i = 0; i < cycles; i++) applyStimulus(0, 0, 8'h00, 0);
  endtask

  task automatic waitDone(input int max_cycles);
    int n = 0;
    while (done !== 1'b1 && n < max_cycles) begin
      applyStimulus(1, 0, 8'h00, 1);
      n++;
    end
    checkValue("done_timeout", done, 1);
  endtask

  initial begin
    $display("[TB] start");
    resetDut(3);

    // Known first word, then the rest of a full image with DRAM always ready.
    sendByte(8'h78, 1, 0); sendByte(8'h56, 1, 0); sendByte(8'h34, 1, 0); sendByte(8'h12, 1, 0);
    checkValue("t1_imem_we", imem_we, 1);
    checkValue("t1_imem_wdata", imem_wdata, 32'h12345678);
    applyStimulus(1, 0, 8'h00, 0);
    checkValue("t1_dram_req", dram_req, 1);
    checkValue("t1_dram_wdata", dram_wdata, 32'h12345678);
    applyStimulus(1, 0, 8'h00, 1);
    checkValue("t1_waddr", waddr, 1);
    for (int w = 1; w < NWORDS; w++) sendWord($urandom, 1, 2);
    waitDone(50);
    checkValue("t2_waddr", waddr, 8);
    checkValue("t2_overflow", overflow, 0);

    // Bytes after completion must be ignored.
    for (int i = 0; i < 8; i++) sendByte(8'($urandom), 1, 1);
    checkValue("t5_waddr", waddr, 8);
    checkValue("t5_dram_req", dram_req, 0);

    // Stalled DRAM: the fifth word is dropped.
    resetDut(2);
    for (int w = 0; w < 5; w++) sendWord($urandom, 0, 0);
    applyStimulus(1, 0, 8'h00, 0);
    checkValue("t3_overflow", overflow, 1);
    for (int i = 0; i < 6; i++) applyStimulus(1, 0, 8'h00, 1);
    for (int w = 5; w < NWORDS; w++) sendWord($urandom, 1, 1);
    waitDone(50);
    checkValue("t3_waddr", waddr, 7);

    // Reset in the middle of a word discards the partial bytes.
    resetDut(2);
    sendByte(8'hAA, 1, 0); sendByte(8'hBB, 1, 0);
    resetDut(1);
    sendWord(32'h00000001, 1, 0);
    checkValue("t4_imem_addr", imem_addr, 0);
    checkValue("t4_imem_wdata", imem_wdata, 32'h1);
    applyStimulus(1, 0, 8'h00, 0);
    checkValue("t4_dram_wdata", dram_wdata, 32'h1);

`ifdef PROG_LOAD_CHECKSUM_EN
    resetDut(2);
    for (int w = 1; w <= NWORDS; w++) sendWord(32'(w), 1, 0);
    waitDone(50);
    checkValue("t6_checksum", checksum, 32'h24);
`endif

    // Randomized loads with a random DRAM acknowledge pattern.
    for (int r = 0; r < 4; r++) begin
      resetDut(2);
      for (int w = 0; w < NWORDS; w++) sendWord($urandom, 2, 3);
      waitDone(100);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
